// File: rtl/gbdt_ram_loader.sv
// gbdt_ram_loader
// Loads the eight per-class tree RAMs from a DMA beat stream before
// inference starts. Beats are packed LSB-first into 32-bit node words.
// Each completed word is written to the RAM of the current class. The
// current class steps through the set bits of used_classes, lowest first.
//
// Ports
//   gbdt_clk, gbdt_rst : clock, synchronous active-high reset
//   load_start         : one-cycle pulse; samples used_classes / words_per_ram
//   used_classes       : mask of class RAMs to fill
//   words_per_ram      : words written to each selected RAM (0..2^RAM_ADDR_WIDTH)
//   DMA_valid/DMA_data : beat stream with no backpressure
//   ram_we/ram_cs      : one-hot write strobe and chip select (identical)
//   ram_address/wdata  : shared write address and data
//   load_busy          : load in progress
//   load_done          : one-cycle completion pulse
//   load_err           : sticky; a beat arrived when none was expected
module gbdt_ram_loader #(
  parameter int DMA_RATE       = 8,
  parameter int RAM_ADDR_WIDTH = 10
) (
  input  logic                      gbdt_clk,
  input  logic                      gbdt_rst,
  input  logic                      load_start,
  input  logic [7:0]                used_classes,
  input  logic [RAM_ADDR_WIDTH:0]   words_per_ram,
  input  logic                      DMA_valid,
  input  logic [DMA_RATE-1:0]       DMA_data,
  output logic [7:0]                ram_we,
  output logic [7:0]                ram_cs,
  output logic [RAM_ADDR_WIDTH-1:0] ram_address,
  output logic [31:0]               ram_wdata,
  output logic                      load_busy,
  output logic                      load_done,
  output logic                      load_err
);

  localparam int         BEATS     = 32 / DMA_RATE;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);
  localparam logic [RAM_ADDR_WIDTH:0] ONE_W = (RAM_ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_e;

  state_e                    state_q, state_d;
  logic [7:0]                mask_q, mask_d;
  logic [RAM_ADDR_WIDTH:0]   wpr_q, wpr_d;
  logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]                cls_q, cls_d;
  logic [1:0]                beat_q, beat_d;
  logic [31:0]               asm_q, asm_d;
  logic                      final_q, final_d;   // last word accepted; no more beats expected
  logic [7:0]                we_q, we_d;
  logic [RAM_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic                      err_q, err_d;
  logic [3:0]                nxt_cls;

  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    lowest_bit = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) lowest_bit = 3'(i);
  endfunction

  // {found, index} of the lowest set mask bit strictly above ptr.
  function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] ptr);
    next_above = 4'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i] && (i > int'(ptr))) next_above = {1'b1, 3'(i)};
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    state_d = state_q;
    mask_d  = mask_q;
    wpr_d   = wpr_q;
    addr_d  = addr_q;
    cls_d   = cls_q;
    beat_d  = beat_q;
    asm_d   = asm_q;
    final_d = final_q;
    we_d    = '0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    nxt_cls = next_above(mask_q, cls_q);

    case (state_q)
      IDLE: begin
        if (load_start) begin
          mask_d  = used_classes;
          wpr_d   = words_per_ram;
          err_d   = 1'b0;
          addr_d  = '0;
          beat_d  = '0;
          asm_d   = '0;
          final_d = 1'b0;
          cls_d   = lowest_bit(used_classes);
          state_d = (used_classes == 8'd0 || words_per_ram == '0) ? FINISH : LOAD;
        end
        if (DMA_valid) err_d = 1'b1;
      end

      LOAD: begin
        if (DMA_valid) begin
          if (final_q) begin
            err_d = 1'b1;
          end else begin
            asm_d[beat_q*DMA_RATE +: DMA_RATE] = DMA_data;
            if (beat_q == LAST_BEAT) begin
              // Word complete: register the write for the next cycle and
              // advance address/class now, so a beat in the write cycle
              // already targets the following slot.
              beat_d  = '0;
              we_d    = 8'd1 << cls_q;
              waddr_d = addr_q;
              wdata_d = asm_d;
              if ({1'b0, addr_q} == wpr_q - ONE_W) begin
                addr_d = '0;
                if (nxt_cls[3]) cls_d   = nxt_cls[2:0];
                else            final_d = 1'b1;
              end else begin
                addr_d = addr_q + 1'b1;
              end
            end else begin
              beat_d = beat_q + 2'd1;
            end
          end
        end
        // final_q is first seen high in the cycle of the final write.
        if (final_q) state_d = FINISH;
      end

      FINISH: begin
        if (DMA_valid) err_d = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gbdt_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (gbdt_rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      wpr_q   <= '0;
      addr_q  <= '0;
      cls_q   <= '0;
      beat_q  <= '0;
      asm_q   <= '0;
      final_q <= 1'b0;
      we_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      wpr_q   <= wpr_d;
      addr_q  <= addr_d;
      cls_q   <= cls_d;
      beat_q  <= beat_d;
      asm_q   <= asm_d;
      final_q <= final_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign ram_we      = we_q;
  assign ram_cs      = we_q;
  assign ram_address = waddr_q;
  assign ram_wdata   = wdata_q;
  assign load_busy   = (state_q != IDLE);
  assign load_done   = (state_q == FINISH);
  assign load_err    = err_q;

endmodule

// File: tb/tb_gbdt_ram_loader.sv
// Scoreboard bench for gbdt_ram_loader. Stimulus pushes expected writes
// and completion pulses into per-instance queues. A negedge monitor pops
// an entry whenever an instance shows ram_we or load_done and compares it.
// Two instances are used: DMA_RATE=8 and DMA_RATE=32.
module tb_gbdt_ram_loader;

  typedef enum int {EV_WR, EV_DONE_WR, EV_DONE_ST} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [7:0]  we;
    logic [9:0]  addr;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  ev_t q_a[$];
  ev_t q_b[$];
  int  last_wr[2];
  int  last_st[2];
  bit  b_consec = 1'b0;
  int  b_nwr    = 0;

  // instance A: 8-bit beats
  logic        a_start = 0, a_valid = 0;
  logic [7:0]  a_mask = 0, a_data = 0;
  logic [10:0] a_wpr = 0;
  logic [7:0]  a_we, a_cs;
  logic [9:0]  a_addr;
  logic [31:0] a_wdata;
  logic        a_busy, a_done, a_err;

  // instance B: 32-bit beats
  logic        b_start = 0, b_valid = 0;
  logic [7:0]  b_mask = 0;
  logic [31:0] b_data = 0;
  logic [10:0] b_wpr = 0;
  logic [7:0]  b_we, b_cs;
  logic [9:0]  b_addr;
  logic [31:0] b_wdata;
  logic        b_busy, b_done, b_err;

  gbdt_ram_loader #(.DMA_RATE(8), .RAM_ADDR_WIDTH(10)) dut_a (
    .gbdt_clk(clk), .gbdt_rst(rst), .load_start(a_start), .used_classes(a_mask),
    .words_per_ram(a_wpr), .DMA_valid(a_valid), .DMA_data(a_data),
    .ram_we(a_we), .ram_cs(a_cs), .ram_address(a_addr), .ram_wdata(a_wdata),
    .load_busy(a_busy), .load_done(a_done), .load_err(a_err));

  gbdt_ram_loader #(.DMA_RATE(32), .RAM_ADDR_WIDTH(10)) dut_b (
    .gbdt_clk(clk), .gbdt_rst(rst), .load_start(b_start), .used_classes(b_mask),
    .words_per_ram(b_wpr), .DMA_valid(b_valid), .DMA_data(b_data),
    .ram_we(b_we), .ram_cs(b_cs), .ram_address(b_addr), .ram_wdata(b_wdata),
    .load_busy(b_busy), .load_done(b_done), .load_err(b_err));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic ev_t mk(input ev_kind_e k, input logic [7:0] we,
                             input logic [9:0] addr, input logic [31:0] data);
    ev_t e;
    e.kind = k; e.we = we; e.addr = addr; e.data = data;
    return e;
  endfunction

  // ---------------- monitor ----------------
  task automatic observe(input int id, input logic [7:0] we, input logic [7:0] cs,
                         input logic [9:0] addr, input logic [31:0] data,
                         input logic done, input logic start);
    ev_t e;
    bit  empty;
    if (start) last_st[id] = cyc;
    if (we != 8'd0 || done) begin
      empty = (id == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
      if (empty) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_event dut%0d: we=%0h done=%0b with nothing expected (cycle %0d)",
                 id, we, done, cyc);
      end else begin
        e = (id == 0) ? q_a.pop_front() : q_b.pop_front();
        if (e.kind == EV_WR) begin
          check($sformatf("dut%0d_write", id), {5'd0, done, we, cs, addr, data},
                {5'd0, 1'b0, e.we, e.we, e.addr, e.data});
        end else begin
          check($sformatf("dut%0d_done", id), {62'd0, (we != 8'd0), done}, 64'd1);
          check($sformatf("dut%0d_done_timing", id),
                64'(cyc - ((e.kind == EV_DONE_WR) ? last_wr[id] : last_st[id])), 64'd1);
        end
      end
      if (we != 8'd0) begin
        if (id == 1 && b_consec) begin
          if (b_nwr > 0) check("dut1_consecutive_write", 64'(cyc - last_wr[1]), 64'd1);
          b_nwr++;
        end
        last_wr[id] = cyc;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      observe(0, a_we, a_cs, a_addr, a_wdata, a_done, a_start);
      observe(1, b_we, b_cs, b_addr, b_wdata, b_done, b_start);
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_beat(input logic [7:0] d);
    a_valid = 1'b1; a_data = d;
    step();
    a_valid = 1'b0;
  endtask

  task automatic a_load(input logic [7:0] m, input logic [10:0] w);
    a_start = 1'b1; a_mask = m; a_wpr = w;
    step();
    a_start = 1'b0;
  endtask

  task automatic a_wait_idle(input string name, input int limit);
    int n = 0;
    while (a_busy && n < limit) begin step(); n++; end
    check({name, "_idle_timeout"}, {63'd0, a_busy}, 64'd0);
  endtask

  task automatic a_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) step();
      a_beat(w[k*8 +: 8]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  int cls_tab[3] = '{2, 5, 7};

  initial begin
    logic [31:0] w;

    // reset state
    repeat (3) step();
    check("reset_outputs_a", {3'd0, a_we, a_cs, a_addr, a_wdata, a_busy, a_done, a_err}, 64'd0);
    check("reset_outputs_b", {3'd0, b_we, b_cs, b_addr, b_wdata, b_busy, b_done, b_err}, 64'd0);
    rst = 1'b0;
    step();

    // 1: single class, two words, back-to-back beats
    q_a.push_back(mk(EV_WR, 8'h01, 10'd0, 32'h44332211));
    q_a.push_back(mk(EV_WR, 8'h01, 10'd1, 32'h88776655));
    q_a.push_back(mk(EV_DONE_WR, 8'h00, 10'd0, 32'd0));
    a_load(8'h01, 11'd2);
    check("busy_after_start", {63'd0, a_busy}, 64'd1);
    for (int k = 0; k < 8; k++) a_beat(8'(8'h11 * (k + 1)));
    a_wait_idle("single", 50);
    check("single_err", {63'd0, a_err}, 64'd0);
    check("single_drained", 64'(q_a.size()), 64'd0);

    // 2: sparse mask with random gaps between beats
    for (int i = 0; i < 9; i++) begin
      w = {8'(16*i + 4), 8'(16*i + 3), 8'(16*i + 2), 8'(16*i + 1)};
      q_a.push_back(mk(EV_WR, 8'(1 << cls_tab[i/3]), 10'(i % 3), w));
    end
    q_a.push_back(mk(EV_DONE_WR, 8'h00, 10'd0, 32'd0));
    a_load(8'hA4, 11'd3);
    for (int i = 0; i < 9; i++) begin
      w = {8'(16*i + 4), 8'(16*i + 3), 8'(16*i + 2), 8'(16*i + 1)};
      a_word(w, 3);
    end
    a_wait_idle("sparse", 200);
    check("sparse_err", {63'd0, a_err}, 64'd0);
    check("sparse_drained", 64'(q_a.size()), 64'd0);

    // 3: empty loads (mask 0, then word count 0)
    q_a.push_back(mk(EV_DONE_ST, 8'h00, 10'd0, 32'd0));
    a_load(8'h00, 11'd5);
    check("empty_mask_busy", {63'd0, a_busy}, 64'd1);
    step();
    check("empty_mask_busy_drop", {63'd0, a_busy}, 64'd0);
    q_a.push_back(mk(EV_DONE_ST, 8'h00, 10'd0, 32'd0));
    a_load(8'hFF, 11'd0);
    check("empty_wpr_busy", {63'd0, a_busy}, 64'd1);
    step();
    check("empty_wpr_busy_drop", {63'd0, a_busy}, 64'd0);
    check("empty_drained", 64'(q_a.size()), 64'd0);

    // 4: error path
    a_beat(8'h5A);
    check("idle_beat_err", {63'd0, a_err}, 64'd1);
    repeat (2) step();
    check("idle_err_sticky", {63'd0, a_err}, 64'd1);
    q_a.push_back(mk(EV_WR, 8'h01, 10'd0, 32'hDEADBEEF));
    q_a.push_back(mk(EV_DONE_WR, 8'h00, 10'd0, 32'd0));
    a_load(8'h01, 11'd1);
    check("start_clears_err", {63'd0, a_err}, 64'd0);
    a_word(32'hDEADBEEF, 0);
    a_beat(8'hEE);
    a_wait_idle("extra_beat", 20);
    check("extra_beat_err", {63'd0, a_err}, 64'd1);
    check("extra_beat_drained", 64'(q_a.size()), 64'd0);

    // 5: reset in the middle of a word
    a_load(8'h02, 11'd2);
    a_beat(8'h01); a_beat(8'h02); a_beat(8'h03);
    rst = 1'b1;
    step();
    check("midreset_outputs", {3'd0, a_we, a_cs, a_addr, a_wdata, a_busy, a_done, a_err}, 64'd0);
    rst = 1'b0;
    repeat (3) step();
    q_a.push_back(mk(EV_WR, 8'h02, 10'd0, 32'hCAFE0123));
    q_a.push_back(mk(EV_DONE_WR, 8'h00, 10'd0, 32'd0));
    a_load(8'h02, 11'd1);
    a_word(32'hCAFE0123, 0);
    a_wait_idle("after_reset", 20);
    check("after_reset_drained", 64'(q_a.size()), 64'd0);

    // 6: 32-bit beats, full RAMs, all classes, continuous
    for (int j = 0; j < 8192; j++)
      q_b.push_back(mk(EV_WR, 8'(1 << (j / 1024)), 10'(j % 1024), 32'hC000_0000 | 32'(j)));
    q_b.push_back(mk(EV_DONE_WR, 8'h00, 10'd0, 32'd0));
    b_consec = 1'b1;
    b_start = 1'b1; b_mask = 8'hFF; b_wpr = 11'd1024;
    step();
    b_start = 1'b0;
    for (int j = 0; j < 8192; j++) begin
      b_valid = 1'b1; b_data = 32'hC000_0000 | 32'(j);
      step();
    end
    b_valid = 1'b0;
    begin
      int n = 0;
      while (b_busy && n < 20) begin step(); n++; end
    end
    check("full_idle_timeout", {63'd0, b_busy}, 64'd0);
    check("full_write_count", 64'(b_nwr), 64'd8192);
    check("full_err", {63'd0, b_err}, 64'd0);
    check("full_drained", 64'(q_b.size()), 64'd0);
    check("a_final_drained", 64'(q_a.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/gbdt_ram_loader.md
Name: gbdt_ram_loader

Overview:
- Write-side counterpart to the per-class tree walkers, which only read the eight tree RAMs.
- Accepts a DMA beat stream of serialized 32-bit tree-node words and assembles full words from it.
- Writes the words sequentially into the class RAMs selected by a class mask, one RAM at a time, before inference starts.
- Sits between the DMA interface and the eight class RAM write ports, alongside the inference core.

Parameters:
- DMA_RATE, 8: bits per DMA beat. Legal values are 8, 16 and 32.
- RAM_ADDR_WIDTH, 10: address width of each class RAM.
- BEATS = 32/DMA_RATE: derived localparam, beats per 32-bit word.

Ports:
- gbdt_clk  in  1  clock; all logic on rising edge.
- gbdt_rst  in  1  synchronous, active-high reset.
- load_start  in  1  single-cycle pulse that starts a load.
- used_classes  in  8  mask of RAMs to fill; sampled on load_start.
- words_per_ram  in  RAM_ADDR_WIDTH+1  words written to each selected RAM; sampled on load_start.
- DMA_valid  in  1  beat qualifier. There is no backpressure; every valid beat must be consumed.
- DMA_data  in  DMA_RATE  beat payload.
- ram_we  out  8  one-hot write strobe, one bit per class RAM.
- ram_cs  out  8  one-hot chip select; equals ram_we.
- ram_address  out  RAM_ADDR_WIDTH  shared write address.
- ram_wdata  out  32  shared write data.
- load_busy  out  1  high while a load is in progress.
- load_done  out  1  single-cycle completion pulse.
- load_err  out  1  sticky flag: a beat arrived while idle.

Behaviour:
- Reset, synchronous: state=IDLE. All outputs are 0. Assembly register, beat counter, address and class pointer are cleared. Reset mid-load aborts the load; no write strobe occurs on the following cycles.
- States: IDLE, LOAD, FINISH.
- IDLE + load_start:
  - Latch mask and word count. Clear load_err. Clear address and beat counter.
  - Class pointer = lowest set bit of the mask.
  - If mask==0 or words_per_ram==0, go to FINISH. Otherwise go to LOAD.
  - load_busy rises the cycle after load_start.
- load_start outside IDLE is ignored.
- IDLE + DMA_valid: the beat is discarded and load_err is set. load_err holds until the next accepted load_start.
- LOAD, word assembly:
  - Each DMA_valid beat k (k=0..BEATS-1) is written to assembly bits [k*DMA_RATE +: DMA_RATE]. The first beat lands in the LSBs.
  - Cycles without DMA_valid leave all state unchanged; gaps of any length are allowed.
- LOAD, RAM write:
  - On the cycle that accepts beat BEATS-1, the word is registered.
  - On the NEXT cycle, exactly one cycle of: ram_we = ram_cs = 1<<class_ptr, ram_address = current address, ram_wdata = word.
  - Write latency is 1 cycle after the last beat.
  - The assembly register is separate from ram_wdata, so a beat arriving in the write cycle is accepted. With DMA_RATE=32, back-to-back beats therefore produce back-to-back writes.
- Address and class advance, evaluated in the write cycle:
  - If address == words_per_ram-1: address=0 and class_ptr = next higher set mask bit.
  - If no higher bit is set, go to FINISH.
  - Otherwise address increments.
  - Writes to a class are never interleaved with writes to another class.
- Beats arriving after the final word's last beat, while still in LOAD/FINISH: discarded and load_err is set.
- FINISH: load_done=1 for one cycle. This is the cycle after the final write, or the cycle after load_start for an empty load. load_busy is still high in that cycle. Next state is IDLE.
- ram_we outside write cycles: 0. ram_address and ram_wdata hold their last values; they are don't-care when ram_we=0.
- Simultaneous gbdt_rst and load_start: reset wins.
- Maximum words_per_ram is 2^RAM_ADDR_WIDTH. The address never wraps within a class.

Test Plan:
- Single class, DMA_RATE=8, used_classes=8'h01, words_per_ram=2, beats 11,22,33,44,55,66,77,88 back-to-back -> ram_we=8'h01 at addr 0 with data 32'h44332211, then addr 1 with data 32'h88776655; load_done one cycle after the second write; load_err=0.
- Sparse mask 8'hA4, words_per_ram=3, 36 beats with random gaps -> writes go to RAM2 addr 0..2, then RAM5 addr 0..2, then RAM7 addr 0..2, in order; never two ram_we bits set; exactly 9 write pulses; one load_done.
- Empty loads: mask 0, and separately words_per_ram=0 -> load_done the cycle after load_start; no ram_we pulses; load_busy high for one cycle.
- Error path: DMA_valid in IDLE -> load_err=1 and no writes. Next load_start clears it. An extra beat after the final word -> load_err=1; the write count is unchanged.
- Reset mid-load: gbdt_rst asserted after 3 beats of word 1 -> the following cycle shows all outputs 0 and no write. A fresh load then writes from addr 0 with correct data.
- DMA_RATE=32, words_per_ram=1024, mask 8'hFF, continuous beats -> 8192 writes on consecutive cycles; the last write goes to RAM7 addr 1023 with no wrap; load_done follows it by one cycle.
